// File: rtl/rom_burst_reader_pkg.sv
// Shared types and ROM contents for the burst-reading program ROM.
package rom_pkg;

    localparam int unsigned ROM_WORDS = 9;

    localparam logic [7:0] ROM_INIT [ROM_WORDS] = '{
        8'h08, 8'h19, 8'h20, 8'h10, 8'h70, 8'h00, 8'h14, 8'h04, 8'hB2
    };

    typedef enum logic {
        IDLE,
        BURST
    } rom_state_e;

endpackage

// File: rtl/rom_burst_reader_if.sv
// Request/response bus of the burst ROM reader; master drives requests, slave answers.
interface rom_burst_reader_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BLEN_W = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [BLEN_W-1:0] req_len;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              rsp_last;
    logic              busy;

    modport master (
        output req_valid, req_addr, req_len, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_last, busy
    );

    modport slave (
        input  req_valid, req_addr, req_len, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err, rsp_last, busy
    );
endinterface

// File: rtl/rom_burst_reader_rom_array.sv
// Combinational ROM lookup; words at or beyond DEPTH read as zero and flag oor.
module rom_array
    import rom_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 9
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              oor_o
);

    always_comb begin
        oor_o  = (int'(addr_i) >= int'(DEPTH));
        data_o = '0;
        // Populated words beyond the init table read as zero
        if (!oor_o && int'(addr_i) < int'(ROM_WORDS)) begin
            data_o = DATA_W'(ROM_INIT[addr_i]);
        end
    end

endmodule

// File: rtl/rom_burst_reader.sv
// Program ROM with valid/ready request port and a registered, stallable burst response.
module rom_burst_reader
    import rom_pkg::*;
#(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 9,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned BLEN_W    = $clog2(MAX_BURST + 1)
) (
    input  logic               clk,
    input  logic               rst,
    rom_burst_reader_if.slave  bus
);

    rom_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BLEN_W-1:0] rem_q, rem_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              last_q, last_d;

    logic [ADDR_W-1:0] lk_addr;
    logic [DATA_W-1:0] lk_data;
    logic              lk_oor;
    logic [BLEN_W-1:0] len_eff;
    logic [BLEN_W-1:0] rem_dec;

    rom_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rom (
        .addr_i (lk_addr),
        .data_o (lk_data),
        .oor_o  (lk_oor)
    );

    always_comb begin
        if (bus.req_len == '0) begin
            len_eff = BLEN_W'(1);
        end else if (bus.req_len > BLEN_W'(MAX_BURST)) begin
            len_eff = BLEN_W'(MAX_BURST);
        end else begin
            len_eff = bus.req_len;
        end
    end

    // The lookup address is the next word to be registered: the request address
    // in IDLE, the successor of the current word during a burst (wraps naturally).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        last_d  = last_q;
        lk_addr = addr_q + ADDR_W'(1);
        rem_dec = rem_q - BLEN_W'(1);

        case (state_q)
            IDLE: begin
                lk_addr = bus.req_addr;
                if (bus.req_valid) begin
                    state_d = BURST;
                    addr_d  = bus.req_addr;
                    rem_d   = len_eff;
                    valid_d = 1'b1;
                    data_d  = lk_data;
                    err_d   = lk_oor;
                    last_d  = (len_eff == BLEN_W'(1));
                end
            end
            BURST: begin
                if (bus.rsp_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        data_d  = '0;
                        err_d   = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        rem_d   = rem_dec;
                        data_d  = lk_data;
                        err_d   = lk_oor;
                        last_d  = (rem_dec == BLEN_W'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_last  = last_q;

endmodule
